// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the frame
// transmit path: states, constants, byte step.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    CRC
  } state_t;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam int          CRC_BYTES       = 4;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ CRC32_POLY_REFL;
      else      r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wide reflected CRC-32 engine with a
// synchronous clear and inverted output.
module crc32
  import crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        is_S1DATA,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] crc32_out
);

  logic [31:0] crc_q;

  // Clear when not in a frame, else fold in valid bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
    end else if (!is_S1DATA) begin
      crc_q <= CRC32_INIT;
    end else if (valid) begin
      crc_q <= crc32_byte(crc_q, data);
    end
  end

  assign crc32_out = ~crc_q;

endmodule

// File: rtl/crc32_frame_tx.sv
// Frame sequencer: passthrough, zero pad to a
// minimum length, then append CRC-32 LSB-first.
module crc32_frame_tx
  import crc_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_len
);

  localparam logic [16:0] MIN_L = 17'(MIN_FRAME_LEN);
  localparam logic [1:0]  LAST_IDX = 2'(CRC_BYTES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] len;
  logic [15:0] len_inc;
  logic        pad_need;
  logic        xfer;
  logic        eng_en;
  logic        eng_vld;
  logic [7:0]  eng_data;
  logic [31:0] crc_out;

  assign len_inc  = (len == 16'hFFFF) ? len : len + 16'd1;
  assign pad_need = {1'b0, len_inc} < MIN_L;
  assign xfer     = m_valid & m_ready;
  assign busy     = (state != IDLE);

  // Output mux: passthrough by default, pad or CRC bytes otherwise
  always_comb begin
    s_ready = m_ready;
    m_valid = s_valid;
    m_data  = s_data;
    m_last  = 1'b0;
    unique case (1'b1)
      (state == PAD): begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = 8'h00;
      end
      (state == CRC): begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = crc_out[{idx, 3'b000} +: 8];
        m_last  = (idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Engine clears between frames and holds while CRC drains
  always_comb begin
    eng_data = (state == PAD) ? 8'h00 : s_data;
    eng_vld  = xfer && (state != CRC);
    eng_en   = 1'b1;
    if (state == IDLE && !xfer)
      eng_en = 1'b0;
    if (state == CRC && idx == LAST_IDX && m_ready)
      eng_en = 1'b0;
  end

  crc32 u_crc32 (
    .clk       (clk),
    .rst       (rst),
    .is_S1DATA (eng_en),
    .valid     (eng_vld),
    .data      (eng_data),
    .crc32_out (crc_out)
  );

  // Frame FSM with byte index, length counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      len        <= 16'd0;
      frame_done <= 1'b0;
      frame_len  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE, DATA: begin
          if (xfer) begin
            len <= len_inc;
            if (s_last)
              state <= pad_need ? PAD : CRC;
            else
              state <= DATA;
          end
        end
        PAD: begin
          if (xfer) begin
            len <= len_inc;
            if (!pad_need)
              state <= CRC;
          end
        end
        CRC: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state      <= IDLE;
              idx        <= 2'd0;
              len        <= 16'd0;
              frame_done <= 1'b1;
              frame_len  <= len;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_frame_tx.sv
// Directed bench for crc32_frame_tx: table of
// frames plus reset and back-to-back sequences.
module tb_crc32_frame_tx;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_data;
  logic s_valid, s_last;
  logic m_ready = 1'b1;

  logic s_ready0, m_valid0, m_last0, busy0, frame_done0;
  logic [7:0] m_data0;
  logic [15:0] frame_len0;
  logic s_ready4, m_valid4, m_last4, busy4, frame_done4;
  logic [7:0] m_data4;
  logic [15:0] frame_len4;

  always #5 clk = ~clk;

  crc32_frame_tx #(.MIN_FRAME_LEN(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0),
    .m_last(m_last0), .m_ready(m_ready),
    .busy(busy0), .frame_done(frame_done0),
    .frame_len(frame_len0)
  );

  crc32_frame_tx #(.MIN_FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready4),
    .m_data(m_data4), .m_valid(m_valid4),
    .m_last(m_last4), .m_ready(m_ready),
    .busy(busy4), .frame_done(frame_done4),
    .frame_len(frame_len4)
  );

  typedef struct {
    string        name;
    int           sel;
    int           n_in;
    logic [127:0] din;
    int           n_out;
    logic [127:0] dout;
    int           flen;
    bit           stall;
  } vec_t;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] q0[$];
  logic [7:0] q4[$];
  bit l0[$];
  bit l4[$];
  int c0[$];
  int fd0 = 0, fd4 = 0;
  bit exp_fd0 = 0, exp_fd4 = 0;
  int tx0 = 0, tx4 = 0;
  int cur_nin = 1000;
  bit srdy_chk = 0;
  bit stall_en = 0;
  bit prev_stall0 = 0;
  logic [7:0] prev_d0;
  logic prev_l0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_en ?
        ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall0 = 0;
      exp_fd0 = 0;
      exp_fd4 = 0;
      tx0 = 0;
      tx4 = 0;
    end else begin
      if (exp_fd0 || frame_done0)
        chk("frame_done0", frame_done0, exp_fd0);
      if (exp_fd4 || frame_done4)
        chk("frame_done4", frame_done4, exp_fd4);
      if (frame_done0) fd0++;
      if (frame_done4) fd4++;
      exp_fd0 = 0;
      exp_fd4 = 0;
      if (prev_stall0) begin
        chk("stall_valid", m_valid0, 1);
        chk("stall_data", m_data0, prev_d0);
        chk("stall_last", m_last0, prev_l0);
      end
      prev_stall0 = m_valid0 && !m_ready;
      prev_d0 = m_data0;
      prev_l0 = m_last0;
      if (srdy_chk && m_valid0 && tx0 >= cur_nin)
        chk("s_ready0_low", s_ready0, 0);
      if (srdy_chk && m_valid4 && tx4 >= cur_nin)
        chk("s_ready4_low", s_ready4, 0);
      if (m_valid0 && m_ready) begin
        q0.push_back(m_data0);
        l0.push_back(m_last0);
        c0.push_back(cyc);
        if (m_last0) begin
          exp_fd0 = 1;
          tx0 = 0;
        end else tx0++;
      end
      if (m_valid4 && m_ready) begin
        q4.push_back(m_data4);
        l4.push_back(m_last4);
        if (m_last4) begin
          exp_fd4 = 1;
          tx4 = 0;
        end else tx4++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d,
                           input bit last);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = last;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = s_ready0 && m_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("xfer_timeout", 0, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] din,
                            input int n);
    for (int i = 0; i < n; i++)
      send_byte(din[127-8*i -: 8], i == n - 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy4) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy0 || busy4) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q0.delete();
    q4.delete();
    l0.delete();
    l4.delete();
    c0.delete();
    fd0 = 0;
    fd4 = 0;
  endtask

  localparam logic [71:0] P9 =
    72'h31_32_33_34_35_36_37_38_39;
  localparam logic [103:0] P9C =
    104'h31_32_33_34_35_36_37_38_39_26_39_F4_CB;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{name:"min0_123456789", sel:0,
      n_in:9, din:{P9, 56'h0}, n_out:13,
      dout:{P9C, 24'h0}, flen:9, stall:0};
    vecs[1] = '{name:"min0_byte00", sel:0,
      n_in:1, din:128'h0, n_out:5,
      dout:{40'h00_8D_EF_02_D2, 88'h0},
      flen:1, stall:0};
    vecs[2] = '{name:"min4_byte00", sel:4,
      n_in:1, din:128'h0, n_out:8,
      dout:{64'h00_00_00_00_1C_DF_44_21, 64'h0},
      flen:4, stall:0};
    vecs[3] = '{name:"min0_stall", sel:0,
      n_in:9, din:{P9, 56'h0}, n_out:13,
      dout:{P9C, 24'h0}, flen:9, stall:1};
    vecs[4] = '{name:"min4_123456789", sel:4,
      n_in:9, din:{P9, 56'h0}, n_out:13,
      dout:{P9C, 24'h0}, flen:9, stall:1};

    rst = 1'b1;
    s_data = 8'h00;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy0, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done0", frame_done0, 0);
    chk("rst_len0", frame_len0, 0);
    chk("rst_len4", frame_len4, 0);
    chk("rst_mvalid0", m_valid0, 0);
    chk("rst_sready0", s_ready0, 1);
    s_data = 8'hA5;
    s_valid = 1'b1;
    @(negedge clk);
    chk("rst_pass_valid", m_valid0, 1);
    chk("rst_pass_data", m_data0, 8'hA5);
    chk("rst_pass_last", m_last0, 0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      clear_mon();
      cur_nin = vecs[k].n_in;
      srdy_chk = 1;
      stall_en = vecs[k].stall;
      send_frame(vecs[k].din, vecs[k].n_in);
      wait_idle();
      stall_en = 0;
      srdy_chk = 0;
      if (vecs[k].sel == 0) begin
        chk({vecs[k].name, "_cnt"}, q0.size(),
            vecs[k].n_out);
        for (int i = 0; i < vecs[k].n_out; i++) begin
          if (i < q0.size()) begin
            chk({vecs[k].name, "_data"}, q0[i],
                vecs[k].dout[127-8*i -: 8]);
            chk({vecs[k].name, "_last"}, l0[i],
                i == vecs[k].n_out - 1);
          end
        end
        chk({vecs[k].name, "_done"}, fd0, 1);
        chk({vecs[k].name, "_flen"}, frame_len0,
            vecs[k].flen);
      end else begin
        chk({vecs[k].name, "_cnt"}, q4.size(),
            vecs[k].n_out);
        for (int i = 0; i < vecs[k].n_out; i++) begin
          if (i < q4.size()) begin
            chk({vecs[k].name, "_data"}, q4[i],
                vecs[k].dout[127-8*i -: 8]);
            chk({vecs[k].name, "_last"}, l4[i],
                i == vecs[k].n_out - 1);
          end
        end
        chk({vecs[k].name, "_done"}, fd4, 1);
        chk({vecs[k].name, "_flen"}, frame_len4,
            vecs[k].flen);
      end
    end

    clear_mon();
    cur_nin = 9;
    srdy_chk = 1;
    send_frame({P9, 56'h0}, 9);
    send_frame({P9, 56'h0}, 9);
    wait_idle();
    srdy_chk = 0;
    chk("b2b_cnt", q0.size(), 26);
    for (int i = 0; i < 26; i++) begin
      if (i < q0.size()) begin
        chk("b2b_data", q0[i],
            P9C[103-8*(i%13) -: 8]);
        chk("b2b_last", l0[i], (i % 13) == 12);
      end
    end
    if (q0.size() >= 14)
      chk("b2b_gap", c0[13] - c0[12], 1);
    chk("b2b_done", fd0, 2);

    clear_mon();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    chk("abort_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_busy0", busy0, 0);
    chk("abort_rst_busy4", busy4, 0);
    chk("abort_rst_done", frame_done0, 0);
    chk("abort_rst_len", frame_len0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_mon();
    send_frame({P9, 56'h0}, 9);
    wait_idle();
    chk("abort_cnt", q0.size(), 13);
    for (int i = 0; i < 13; i++)
      if (i < q0.size())
        chk("abort_data", q0[i], P9C[103-8*i -: 8]);
    chk("abort_done", fd0, 1);
    chk("abort_flen", frame_len0, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc32_frame_tx.md
# crc32_frame_tx

Transmit-side frame sequencer for the `crc32` engine. Accepts a byte stream framed by `s_last` and forwards it downstream. Pads short frames with 0x00 up to `MIN_FRAME_LEN`. Appends the 4-byte CRC-32 (reflected 0xEDB88320, init 0xFFFFFFFF, final inversion) LSB-first. Owns the engine's clear/enable sequencing so back-to-back frames need no idle gap.

## Interface
Parameters:
- `MIN_FRAME_LEN`, default 60: minimum payload bytes before the CRC; 0 disables padding. Legal range 0..65535.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_data`  in  8  upstream payload byte.
- `s_valid`  in  1  upstream byte valid.
- `s_last`  in  1  marks final payload byte of the frame.
- `s_ready`  out  1  upstream may transfer.
- `m_data`  out  8  downstream byte.
- `m_valid`  out  1  downstream byte valid.
- `m_last`  out  1  marks final CRC byte.
- `m_ready`  in  1  downstream accepts.
- `busy`  out  1  frame in progress (state != IDLE).
- `frame_done`  out  1  one-cycle pulse, registered, the cycle after the last CRC byte transfers.
- `frame_len`  out  16  payload+pad length of the last completed frame.

## Operation
- Transfer occurs when valid & ready are both high at a rising `clk`.
- States:
  - IDLE: passthrough. `s_ready`=`m_ready`, `m_valid`=`s_valid`, `m_data`=`s_data`, `m_last`=0.
    - Accept with `s_last`=0 → DATA.
    - Accept with `s_last`=1 → PAD if 1 < `MIN_FRAME_LEN`, else CRC.
  - DATA: same passthrough as IDLE.
    - Accept with `s_last` → PAD if len+1 < `MIN_FRAME_LEN`, else CRC.
  - PAD: `s_ready`=0, `m_valid`=1, `m_data`=0x00.
    - Each pad byte is fed to the engine.
    - → CRC on the transfer that brings len to `MIN_FRAME_LEN`.
  - CRC: `s_ready`=0, `m_valid`=1.
    - `m_data`=`crc32_out[8*idx+7:8*idx]`, idx 0..3.
    - `m_last`=(idx==3).
    - idx increments per transfer.
    - Transfer at idx 3 → IDLE, `frame_done` set next cycle, `frame_len` latched.
- Engine drive:
  - Engine byte input = `s_data` in IDLE/DATA, 0x00 in PAD.
  - Engine `valid` = downstream transfer in IDLE/DATA/PAD; 0 in CRC (engine holds).
  - Engine `is_S1DATA` = 0 when (IDLE and no transfer) or (CRC, idx 3, `m_ready`); else 1. This clears the engine to 0xFFFFFFFF at the edge ending each frame.
- Length counter:
  - 16-bit, counts payload+pad transfers.
  - Cleared on entry to IDLE; first accept loads 1.
  - Saturates at 0xFFFF with no wrap.
  - Padding decisions use the saturated value.
- Zero-length frames do not exist: `s_last` always accompanies a byte.

## Timing
- Payload latency 0 cycles. Combinational paths `s_valid`→`m_valid`, `s_data`→`m_data`, `m_ready`→`s_ready` in IDLE/DATA.
- First CRC byte is presented the cycle after the last payload/pad transfer, with no bubble. Engine output is registered and valid then.
- Backpressure: while `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` hold stable and idx does not advance. The engine does not update.
- Back-to-back frames: a new first byte may transfer the cycle after the idx-3 CRC transfer. The engine is already cleared at that point.
- `m_last`=1 only on CRC idx 3; upstream `s_last` is never forwarded.
- Reset (any time, including mid-frame or mid-CRC):
  - Internal: state IDLE, idx 0, len 0.
  - Registered outputs: `frame_done`=0, `frame_len`=0, `busy`=0.
  - Engine returns to 0xFFFFFFFF.
  - Combinational outputs follow IDLE passthrough.
  - The aborted frame produces no CRC bytes.

## Structure
- Shared package `crc_pkg`: state enum (IDLE, DATA, PAD, CRC), `CRC32_INIT` = 32'hFFFFFFFF, `CRC32_POLY_REFL` = 32'hEDB88320, `CRC_BYTES` = 4.
- One sub-module: existing `crc32` engine instantiated as `u_crc32`. Its clock/reset are tied to `clk`/`rst`.
- FSM, idx counter, length counter and output mux are local.

## Test plan
- `MIN_FRAME_LEN`=0, payload "123456789" (0x31..0x39), `m_ready`=1 → out 31..39, 26, 39, F4, CB. `m_last` on CB; `frame_done` pulse; `frame_len`=9.
- `MIN_FRAME_LEN`=0, single byte 0x00 with `s_last` → out 00, 8D, EF, 02, D2. `m_last` on D2.
- `MIN_FRAME_LEN`=4, single byte 0x00 → out 00, 00, 00, 00, 1C, DF, 44, 21. `s_ready`=0 during pad/CRC; `frame_len`=4.
- Random `m_ready` stalls during payload and CRC idx 2 → identical byte sequence to the no-stall case; `m_data` stable while stalled.
- Back-to-back "123456789" twice, with second frame's first byte offered immediately → both CRCs are CB F43926 (bytes 26 39 F4 CB). No idle cycle between frames.
- `rst` pulsed mid-payload, then "123456789" sent → no CRC emitted for the aborted frame. Next frame's CRC bytes are 26 39 F4 CB; `busy`=0 and `frame_done`=0 during reset.
